// File: rtl/ex_wb_squash_queue.sv
// ex_wb_squash_queue: execute->writeback buffer with one in-order FIFO per
// execute pipe, round-robin merge onto a single writeback port, and squash
// of buffered results younger than a granted squash.
module ex_wb_squash_queue #(
    parameter int p_num_chans    = 4,
    parameter int p_depth        = 2,
    parameter int p_seq_num_bits = 5,
    parameter int p_msg_bits     = 76
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [p_num_chans-1:0]                  in_val,
    output logic [p_num_chans-1:0]                  in_rdy,
    input  logic [p_num_chans*p_seq_num_bits-1:0]   in_seq_num,
    input  logic [p_num_chans*p_msg_bits-1:0]       in_msg,
    output logic                                    out_val,
    input  logic                                    out_rdy,
    output logic [$clog2(p_num_chans)-1:0]          out_chan,
    output logic [p_seq_num_bits-1:0]               out_seq_num,
    output logic [p_msg_bits-1:0]                   out_msg,
    input  logic                                    squash_val,
    input  logic [p_seq_num_bits-1:0]               squash_seq_num,
    input  logic [p_seq_num_bits-1:0]               oldest_seq_num,
    output logic [$clog2(p_num_chans*p_depth+1)-1:0] occupancy
);

    localparam int N     = p_num_chans;
    localparam int D     = p_depth;
    localparam int S     = p_seq_num_bits;
    localparam int M     = p_msg_bits;
    localparam int CH_W  = $clog2(N);
    localparam int PTR_W = (D > 1) ? $clog2(D) : 1;
    localparam int CNT_W = $clog2(D + 1);
    localparam int OCC_W = $clog2(N * D + 1);

    // Per-channel FIFO storage (no reset needed: only read behind a count)
    logic [S-1:0]     seq_mem_q [N][D];
    logic [M-1:0]     msg_mem_q [N][D];

    logic [PTR_W-1:0] head_q  [N];
    logic [PTR_W-1:0] head_d  [N];
    logic [CNT_W-1:0] count_q [N];
    logic [CNT_W-1:0] count_d [N];
    logic [CH_W-1:0]  rr_q;
    logic [CH_W-1:0]  rr_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    logic [CNT_W-1:0] kept  [N];
    logic [N-1:0]     cand;
    logic [N-1:0]     wr_en;
    logic [PTR_W-1:0] wr_ptr [N];
    logic [S-1:0]     sq_age;
    logic             grant_found;
    logic [CH_W-1:0]  grant;
    logic             xfer;

    // Age relative to the oldest uncommitted instruction; wraps naturally
    function automatic logic [S-1:0] age_of(input logic [S-1:0] s, input logic [S-1:0] base);
        return s - base;
    endfunction

    // Ready depends on registered count only; deasserted while in reset
    always_comb begin
        for (int unsigned c = 0; c < N; c++) begin
            in_rdy[c] = rst && (count_q[c] != CNT_W'(D));
        end
    end

    // Squash survivors per channel: length of the leading run not younger than the squash
    always_comb begin
        logic             run;
        logic [PTR_W-1:0] idx;
        run    = 1'b0;
        idx    = '0;
        sq_age = age_of(squash_seq_num, oldest_seq_num);
        for (int unsigned c = 0; c < N; c++) begin
            kept[c] = count_q[c];
            if (squash_val) begin
                kept[c] = '0;
                run     = 1'b1;
                for (int unsigned i = 0; i < D; i++) begin
                    idx = PTR_W'((32'(head_q[c]) + i) % D);
                    if (run && (i < 32'(count_q[c])) &&
                        !(age_of(seq_mem_q[c][idx], oldest_seq_num) > sq_age)) begin
                        kept[c] = kept[c] + CNT_W'(1);
                    end else begin
                        run = 1'b0;
                    end
                end
            end
            // A head that survives the squash is a live candidate
            cand[c] = (count_q[c] != '0) && (kept[c] != '0);
        end
    end

    // Round-robin pick: first candidate at or after rr_q, wrapping
    always_comb begin
        logic [CH_W-1:0] idx;
        idx         = '0;
        grant_found = 1'b0;
        grant       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = CH_W'((32'(rr_q) + k) % N);
            if (!grant_found && cand[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
    end

    // Writeback port driven from the granted head, zeroed when idle
    always_comb begin
        out_val     = grant_found;
        out_chan    = '0;
        out_seq_num = '0;
        out_msg     = '0;
        if (grant_found) begin
            out_chan    = grant;
            out_seq_num = seq_mem_q[grant][head_q[grant]];
            out_msg     = msg_mem_q[grant][head_q[grant]];
        end
    end

    // Next-state: pop, truncate, append the surviving enqueue beat, and sum occupancy
    always_comb begin
        logic             pop;
        logic             enq_keep;
        logic [S-1:0]     in_seq_c;
        pop      = 1'b0;
        enq_keep = 1'b0;
        in_seq_c = '0;
        xfer     = grant_found && out_rdy;
        rr_d     = rr_q;
        occ_d    = '0;
        if (xfer) begin
            rr_d = CH_W'((32'(grant) + 1) % N);
        end
        for (int unsigned c = 0; c < N; c++) begin
            in_seq_c = in_seq_num[c*S +: S];
            enq_keep = in_val[c] && in_rdy[c] &&
                       !(squash_val && (age_of(in_seq_c, oldest_seq_num) > sq_age));
            pop      = xfer && (grant == CH_W'(c));
            head_d[c]  = pop ? PTR_W'((32'(head_q[c]) + 1) % D) : head_q[c];
            // The new beat lands just past the surviving entries, relative to the old head
            wr_en[c]   = enq_keep;
            wr_ptr[c]  = PTR_W'((32'(head_q[c]) + 32'(kept[c])) % D);
            count_d[c] = kept[c] - CNT_W'(pop) + CNT_W'(enq_keep);
            occ_d      = occ_d + OCC_W'(count_d[c]);
        end
    end

    // Control state: async active-low reset clears counts, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < N; c++) begin
                head_q[c]  <= '0;
                count_q[c] <= '0;
            end
            rr_q  <= '0;
            occ_q <= '0;
        end else begin
            for (int unsigned c = 0; c < N; c++) begin
                head_q[c]  <= head_d[c];
                count_q[c] <= count_d[c];
            end
            rr_q  <= rr_d;
            occ_q <= occ_d;
        end
    end

    // Payload storage write for accepted, non-squashed beats
    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < N; c++) begin
            if (wr_en[c]) begin
                seq_mem_q[c][wr_ptr[c]] <= in_seq_num[c*S +: S];
                msg_mem_q[c][wr_ptr[c]] <= in_msg[c*M +: M];
            end
        end
    end

    assign occupancy = occ_q;

endmodule
